next_pc_gen: RTL and testbench
==============================

Name: next_pc_gen

Overview:
- Parametrised, registered successor to the combinational offset/jump-address concatenators.
- Builds the next fetch address for one of five modes: sequential, conditional branch, jump, register jump, exception vector.
- Sits between decode/execute and the PC register. One-stage valid/ready pipeline with backpressure.
- Flags misaligned register targets and counts PC redirects.

Parameters:
- ADDR_W, 32, address width; must satisfy ADDR_W >= IDX_W+ALIGN_SH+1.
- IDX_W, 26, jump index field width.
- IMM_W, 16, branch immediate width; sign-extended.
- ALIGN_SH, 2, instruction alignment shift (log2 of instruction bytes).
- EXC_VEC, 32'h8000_0180, exception vector address; low ADDR_W bits used.
- CNT_W, 16, redirect counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- mode  in  3  000 SEQ, 001 BRANCH, 010 JUMP, 011 REG, 100 EXC, 101-111 reserved.
- pc_in  in  ADDR_W  PC of the current instruction.
- imm  in  IMM_W  branch offset, in instructions.
- index  in  IDX_W  jump index field.
- rs_val  in  ADDR_W  register-jump target.
- taken  in  1  branch condition; used only in BRANCH.
- out_valid  out  1  target valid.
- out_ready  in  1  consumer ready.
- target  out  ADDR_W  next PC.
- exc  out  1  target is EXC_VEC due to misalignment or reserved mode.
- redirect  out  1  target != pc_in + (1<<ALIGN_SH).
- redirect_cnt  out  CNT_W  saturating count of redirects.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: out_valid=0, target=0, exc=0, redirect=0, redirect_cnt=0. in_ready rises combinationally once out_valid=0.
- in_ready = !out_valid || out_ready. Combinational, no dependence on in_valid.
- On accept, the result is registered. out_valid=1 the next cycle, so latency is 1 cycle.
- Full throughput of one result per cycle while out_ready=1.
- If out_valid && !out_ready:
  - target, exc, redirect and out_valid hold stable.
  - in_ready=0, so no new request is accepted.
- If out_valid && out_ready && !in_valid: out_valid clears next cycle. target holds its last value.
- Per-mode target computation (seq = pc_in + (1<<ALIGN_SH)):
  - SEQ: target = seq.
  - BRANCH: if taken, target = seq + (sign_extend(imm) << ALIGN_SH); otherwise target = seq.
  - JUMP: target = {pc_in[ADDR_W-1 : IDX_W+ALIGN_SH], index, ALIGN_SH'b0}.
  - REG: if rs_val[ALIGN_SH-1:0] == 0, target = rs_val; otherwise target = EXC_VEC and exc=1.
  - EXC: target = EXC_VEC, exc=1.
  - Reserved (101-111): target = EXC_VEC, exc=1.
- Width rules:
  - All arithmetic is done in ADDR_W bits and wraps modulo 2^ADDR_W, with no overflow flag.
  - sign_extend uses imm[IMM_W-1].
- redirect is registered alongside target and compares the final target against seq.
- redirect_cnt increments by 1 on each accepted request whose redirect=1. It saturates at all-ones and never wraps.
- Reset mid-operation: a pending output is dropped (out_valid=0 next cycle) and redirect_cnt clears. A request presented during the reset cycle is not accepted.
- No combinational path from the request inputs to the outputs. The only combinational path is out_ready -> in_ready.

Test Plan:
- JUMP, pc_in=0x9000_0010, index=0x000_0040 -> target=0x9000_0100 one cycle later, redirect=1, exc=0, redirect_cnt=1.
- BRANCH, pc_in=0x0000_1000, imm=0xFFFE:
  - taken=1 -> target=0x0000_0FFC, redirect=1.
  - taken=0 -> target=0x0000_1004, redirect=0; redirect_cnt unchanged by the not-taken branch.
- REG misaligned, rs_val=0x0000_2002 -> target=0x8000_0180, exc=1. Then rs_val=0x0000_2000 -> target=0x0000_2000, exc=0.
- SEQ wrap, pc_in=0xFFFF_FFFC -> target=0x0000_0000, redirect=0. Then reserved mode=111 -> target=0x8000_0180, exc=1.
- Backpressure: accept request A, then hold out_ready=0 for 3 cycles with request B pending.
  - During the stall: in_ready=0 and target holds A.
  - After out_ready=1: A drains, B is accepted, and B appears the following cycle.
- Reset and saturation:
  - Force CNT_W=4 and issue 20 JUMP redirects -> redirect_cnt stops at 0xF.
  - Assert reset while out_valid=1 -> next cycle out_valid=0 and redirect_cnt=0.

Source files
------------

// File: rtl/next_pc_gen.sv
// next_pc_gen: registered next-fetch-address generator.
//
// Computes the next PC for one of five modes (sequential, conditional branch,
// jump, register jump, exception vector) and presents it through a one-stage
// valid/ready pipeline with backpressure. Misaligned register targets and
// reserved modes are redirected to the exception vector. A saturating counter
// tracks how many accepted requests redirected the PC.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   request valid
//   in_ready     out  request accepted when in_valid && in_ready
//   mode         in   3'b000 SEQ, 001 BRANCH, 010 JUMP, 011 REG, 100 EXC,
//                     101-111 reserved (treated as EXC)
//   pc_in        in   PC of the current instruction
//   imm          in   branch offset in instructions (sign-extended)
//   index        in   jump index field
//   rs_val       in   register-jump target
//   taken        in   branch condition (BRANCH only)
//   out_valid    out  target valid
//   out_ready    in   consumer ready
//   target       out  next PC
//   exc          out  target is the exception vector
//   redirect     out  target differs from the sequential successor
//   redirect_cnt out  saturating count of redirects
module next_pc_gen #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IDX_W    = 26,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned ALIGN_SH = 2,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0180,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [IMM_W-1:0]  imm,
  input  logic [IDX_W-1:0]  index,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] target,
  output logic              exc,
  output logic              redirect,
  output logic [CNT_W-1:0]  redirect_cnt
);

  typedef enum logic [2:0] {
    MODE_SEQ    = 3'b000,
    MODE_BRANCH = 3'b001,
    MODE_JUMP   = 3'b010,
    MODE_REG    = 3'b011,
    MODE_EXC    = 3'b100
  } mode_e;

  localparam logic [ADDR_W-1:0] EXC_ADDR    = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(1) << ALIGN_SH;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              exc_q, exc_d;
  logic              redirect_q, redirect_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

  logic              accept;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] calc_target;
  logic              calc_exc;
  logic              calc_redirect;

  // Only out_ready reaches in_ready combinationally; the slot is free when
  // empty or when its current contents drain this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    seq_addr    = pc_in + INSTR_BYTES;
    imm_ext     = ADDR_W'($signed(imm));
    calc_target = seq_addr;
    calc_exc    = 1'b0;
    case (mode)
      MODE_SEQ: calc_target = seq_addr;
      MODE_BRANCH: begin
        if (taken) calc_target = seq_addr + (imm_ext << ALIGN_SH);
      end
      MODE_JUMP: begin
        calc_target = {pc_in[ADDR_W-1:IDX_W+ALIGN_SH], index, {ALIGN_SH{1'b0}}};
      end
      MODE_REG: begin
        if (rs_val[ALIGN_SH-1:0] == '0) begin
          calc_target = rs_val;
        end else begin
          calc_target = EXC_ADDR;
          calc_exc    = 1'b1;
        end
      end
      default: begin
        calc_target = EXC_ADDR;
        calc_exc    = 1'b1;
      end
    endcase
    calc_redirect = (calc_target != seq_addr);
  end

  always_comb begin
    out_valid_d    = in_ready ? in_valid : out_valid_q;
    target_d       = target_q;
    exc_d          = exc_q;
    redirect_d     = redirect_q;
    redirect_cnt_d = redirect_cnt_q;
    if (accept) begin
      target_d   = calc_target;
      exc_d      = calc_exc;
      redirect_d = calc_redirect;
      if (calc_redirect && (redirect_cnt_q != '1)) begin
        redirect_cnt_d = redirect_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      target_q       <= '0;
      exc_q          <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      target_q       <= target_d;
      exc_q          <= exc_d;
      redirect_q     <= redirect_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign target       = target_q;
  assign exc          = exc_q;
  assign redirect     = redirect_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_next_pc_gen.sv
// Directed testbench for next_pc_gen (instantiated with a 4-bit redirect
// counter so saturation is reachable in a short run).
module tb_next_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  mode;
  logic [31:0] pc_in;
  logic [15:0] imm;
  logic [25:0] index;
  logic [31:0] rs_val;
  logic        taken;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] target;
  logic        exc;
  logic        redirect;
  logic [3:0]  redirect_cnt;

  int n_pass  = 0;
  int n_total = 0;

  next_pc_gen #(
    .ADDR_W  (32),
    .IDX_W   (26),
    .IMM_W   (16),
    .ALIGN_SH(2),
    .EXC_VEC (32'h8000_0180),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .pc_in       (pc_in),
    .imm         (imm),
    .index       (index),
    .rs_val      (rs_val),
    .taken       (taken),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .target      (target),
    .exc         (exc),
    .redirect    (redirect),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] m, input logic [31:0] pc, input logic [15:0] im,
                       input logic [25:0] idx, input logic [31:0] rs, input logic tk);
    in_valid = 1'b1;
    mode     = m;
    pc_in    = pc;
    imm      = im;
    index    = idx;
    rs_val   = rs;
    taken    = tk;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] t, input logic e,
                           input logic r, input logic [3:0] c);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".target"}, target, t);
    check({tag, ".exc"}, {31'b0, exc}, {31'b0, e});
    check({tag, ".redirect"}, {31'b0, redirect}, {31'b0, r});
    check({tag, ".cnt"}, {28'b0, redirect_cnt}, {28'b0, c});
  endtask

  initial begin
    logic [3:0] exp_cnt;
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    mode      = 3'b000;
    pc_in     = '0;
    imm       = '0;
    index     = '0;
    rs_val    = '0;
    taken     = 1'b0;
    tick();
    tick();
    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.target", target, 32'h0);
    check("rst.exc", {31'b0, exc}, 32'd0);
    check("rst.redirect", {31'b0, redirect}, 32'd0);
    check("rst.cnt", {28'b0, redirect_cnt}, 32'd0);
    check("rst.in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;

    // Back-to-back requests at full throughput.
    drive(3'b010, 32'h9000_0010, 16'h0, 26'h000_0040, 32'h0, 1'b0);
    tick();
    check_out("jump", 32'h9000_0100, 1'b0, 1'b1, 4'd1);
    drive(3'b001, 32'h0000_1000, 16'hFFFE, 26'h0, 32'h0, 1'b1);
    tick();
    check_out("br_taken", 32'h0000_0FFC, 1'b0, 1'b1, 4'd2);
    drive(3'b001, 32'h0000_1000, 16'hFFFE, 26'h0, 32'h0, 1'b0);
    tick();
    check_out("br_not", 32'h0000_1004, 1'b0, 1'b0, 4'd2);
    drive(3'b001, 32'h0000_0010, 16'h0003, 26'h0, 32'h0, 1'b1);
    tick();
    check_out("br_fwd", 32'h0000_0020, 1'b0, 1'b1, 4'd3);
    drive(3'b011, 32'h0000_0100, 16'h0, 26'h0, 32'h0000_2002, 1'b0);
    tick();
    check_out("reg_mis", 32'h8000_0180, 1'b1, 1'b1, 4'd4);
    drive(3'b011, 32'h0000_0100, 16'h0, 26'h0, 32'h0000_2000, 1'b0);
    tick();
    check_out("reg_ok", 32'h0000_2000, 1'b0, 1'b1, 4'd5);
    drive(3'b000, 32'hFFFF_FFFC, 16'h0, 26'h0, 32'h0, 1'b0);
    tick();
    check_out("seq_wrap", 32'h0000_0000, 1'b0, 1'b0, 4'd5);
    drive(3'b111, 32'h0000_0200, 16'h0, 26'h0, 32'h0, 1'b0);
    tick();
    check_out("rsvd", 32'h8000_0180, 1'b1, 1'b1, 4'd6);
    // Vector equals the sequential successor: exception but no redirect.
    drive(3'b100, 32'h8000_017C, 16'h0, 26'h0, 32'h0, 1'b0);
    tick();
    check_out("exc_seq", 32'h8000_0180, 1'b1, 1'b0, 4'd6);

    in_valid = 1'b0;
    tick();
    check("drain.valid", {31'b0, out_valid}, 32'd0);
    check("drain.target", target, 32'h8000_0180);

    // Backpressure: A accepted, B held pending while the consumer stalls.
    drive(3'b000, 32'h0000_0040, 16'h0, 26'h0, 32'h0, 1'b0);
    tick();
    check_out("bp_a", 32'h0000_0044, 1'b0, 1'b0, 4'd6);
    drive(3'b010, 32'h0000_0000, 16'h0, 26'h000_0010, 32'h0, 1'b0);
    out_ready = 1'b0;
    #1;
    check("bp.in_ready0", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.stall_ready", {31'b0, in_ready}, 32'd0);
      check_out("bp_hold", 32'h0000_0044, 1'b0, 1'b0, 4'd6);
    end
    out_ready = 1'b1;
    #1;
    check("bp.in_ready1", {31'b0, in_ready}, 32'd1);
    tick();
    check_out("bp_b", 32'h0000_0040, 1'b0, 1'b1, 4'd7);

    // Saturation of the 4-bit redirect counter.
    exp_cnt = 4'd7;
    for (int i = 0; i < 20; i++) begin
      drive(3'b010, 32'h0, 16'h0, 26'(i + 2), 32'h0, 1'b0);
      tick();
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
      check("sat.cnt", {28'b0, redirect_cnt}, {28'b0, exp_cnt});
    end
    check("sat.final", {28'b0, redirect_cnt}, 32'hF);
    check("sat.target", target, (32'd21) << 2);

    // Reset with a pending output and a request presented during reset.
    out_ready = 1'b0;
    drive(3'b010, 32'h0, 16'h0, 26'h55, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst.valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst.cnt", {28'b0, redirect_cnt}, 32'd0);
    check("mid_rst.target", target, 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst.valid", {31'b0, out_valid}, 32'd0);
    check("post_rst.cnt", {28'b0, redirect_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
